// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle RV32I control FSM with a shared memory port.
// It handles the memory handshake timeout, traps, and counts retired instructions.
// Optional build macro MULTICYCLE_LUI_EN makes LUI (0110111) a legal opcode.
module multicycle_ctrl #(
    parameter int unsigned TMO_W       = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [6:0]       Opcode,
    input  logic [2:0]       Funct3,
    input  logic             Zero,
    input  logic             Mem_ready,
    output logic             MemReq,
    output logic             MemWe,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic [1:0]       MemtoReg,
    output logic             Trap,
    output logic [1:0]       Trap_cause,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWR, S_WB_MEM,
        S_EXEC_R, S_EXEC_I, S_WB_ALU, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
`ifdef MULTICYCLE_LUI_EN
    localparam logic [6:0] OP_LUI = 7'b0110111;
`endif

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

    localparam logic [1:0] C_ILLEGAL = 2'd1;
    localparam logic [1:0] C_TIMEOUT = 2'd2;
    localparam logic [1:0] C_BRF3    = 2'd3;

    state_t           r_state;
    state_t           w_next;
    logic [TMO_W-1:0] r_tmo;
    logic             r_trap;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_retired;
    logic             w_wait;
    logic             w_tmo_hit;
    logic             w_trap_set;
    logic [1:0]       w_cause;
    logic             w_retire;

    assign w_tmo_hit  = (r_tmo == TMO_LIM);
    assign Trap       = r_trap;
    assign Trap_cause = r_cause;
    assign Retired    = r_retired;

    // Next-state and control outputs decoded from the current state.
    always_comb begin
        w_next     = r_state;
        w_wait     = 1'b0;
        w_trap_set = 1'b0;
        w_cause    = 2'd0;
        w_retire   = 1'b0;
        MemReq     = 1'b0;
        MemWe      = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ALUOp      = 2'd0;
        RegWrite   = 1'b0;
        MemtoReg   = 2'd0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = 2'd1;
                w_wait  = 1'b1;
                if (Mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_tmo_hit) begin
                    w_next     = S_TRAP;
                    w_trap_set = 1'b1;
                    w_cause    = C_TIMEOUT;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'd2;
                ALUSrcB = 2'd2;
                case (Opcode)
                    OP_R:         w_next = S_EXEC_R;
                    OP_I:         w_next = S_EXEC_I;
`ifdef MULTICYCLE_LUI_EN
                    OP_LUI:       w_next = S_EXEC_I;
`endif
                    OP_LD, OP_ST: w_next = S_MEMADR;
                    OP_BR:        w_next = S_BRANCH;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_next     = S_TRAP;
                        w_trap_set = 1'b1;
                        w_cause    = C_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                w_next  = (Opcode == OP_LD) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD, S_MEMWR: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                MemWe  = (r_state == S_MEMWR);
                w_wait = 1'b1;
                if (Mem_ready) begin
                    if (r_state == S_MEMRD) begin
                        w_next = S_WB_MEM;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_next     = S_TRAP;
                    w_trap_set = 1'b1;
                    w_cause    = C_TIMEOUT;
                end
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_EXEC_R: begin
                ALUSrcA = 2'd1;
                ALUOp   = 2'b10;
                w_next  = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ALUOp   = 2'b10;
`ifdef MULTICYCLE_LUI_EN
                // LUI adds the immediate to a constant zero operand.
                if (Opcode == OP_LUI) begin
                    ALUSrcA = 2'd3;
                    ALUOp   = 2'b00;
                end
`endif
                w_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                RegWrite = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 2'd1;
                ALUOp   = 2'b01;
                PCSrc   = 1'b1;
                case (Funct3)
                    3'b000: begin
                        PCWrite  = Zero;
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    3'b001: begin
                        PCWrite  = ~Zero;
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                    default: begin
                        w_next     = S_TRAP;
                        w_trap_set = 1'b1;
                        w_cause    = C_BRF3;
                    end
                endcase
            end
            S_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = 2'd2;
                PCWrite  = 1'b1;
                PCSrc    = 1'b1;
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Wait-state counter: counts unanswered memory cycles only.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            r_tmo <= '0;
        else if (w_wait && !Mem_ready && !w_tmo_hit)
            r_tmo <= r_tmo + TMO_W'(1);
        else
            r_tmo <= '0;
    end

    // Sticky trap flag and cause, latched on entry to TRAP.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_trap  <= 1'b0;
            r_cause <= 2'd0;
        end else if (w_trap_set) begin
            r_trap  <= 1'b1;
            r_cause <= w_cause;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)           r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vector table plus hand sequences for multicycle_ctrl.
// Define MULTICYCLE_LUI_EN to check the LUI-enabled build.
module tb_multicycle_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [6:0]  Opcode = '0;
    logic [2:0]  Funct3 = '0;
    logic        Zero = 1'b0;
    logic        Mem_ready = 1'b0;
    logic        MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, MemtoReg, Trap_cause;
    logic        RegWrite, Trap;
    logic [31:0] Retired;

    multicycle_ctrl dut (
        .Clk(Clk), .Rst(Rst), .Opcode(Opcode), .Funct3(Funct3),
        .Zero(Zero), .Mem_ready(Mem_ready), .MemReq(MemReq),
        .MemWe(MemWe), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .Trap(Trap), .Trap_cause(Trap_cause),
        .Retired(Retired)
    );

    always #5 Clk = ~Clk;

    localparam logic [6:0] OR_ = 7'h33, OI = 7'h13, OL = 7'h03, OS = 7'h23;
    localparam logic [6:0] OB = 7'h63, OJ = 7'h6F, OU = 7'h37, OX = 7'h7F;

    typedef struct {
        logic        r;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        z;
        logic        rdy;
        logic [14:0] ctl;
        logic        tr;
        logic [1:0]  cs;
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [14:0] w_ctl;
    assign w_ctl = {MemReq, MemWe, IorD, IRWrite, PCWrite, PCSrc,
                    ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg};

    logic [14:0] E_0, E_FW, E_FR, E_DEC, E_MA, E_MR, E_MW, E_WBM;
    logic [14:0] E_XR, E_XI, E_WBA, E_BT, E_BN, E_JAL, E_LUI;

    function automatic logic [14:0] c(
        input logic mr, mw, iord, irw, pcw, pcs,
        input logic [1:0] a, b, op,
        input logic rw,
        input logic [1:0] m2r
    );
        return {mr, mw, iord, irw, pcw, pcs, a, b, op, rw, m2r};
    endfunction

    task automatic chk(input string nm, input logic [49:0] got,
                       input logic [49:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input string nm, input logic r,
                        input logic [6:0] op, input logic [2:0] f3,
                        input logic z, input logic rdy,
                        input logic [14:0] ctl, input logic tr,
                        input logic [1:0] cs, input logic [31:0] ret);
        @(negedge Clk);
        Rst = r; Opcode = op; Funct3 = f3; Zero = z; Mem_ready = rdy;
        #2;
        chk(nm, {w_ctl, Trap, Trap_cause, Retired}, {ctl, tr, cs, ret});
    endtask

    task automatic add(input logic r, input logic [6:0] op,
                       input logic [2:0] f3, input logic z,
                       input logic rdy, input logic [14:0] ctl,
                       input logic tr, input logic [1:0] cs,
                       input logic [31:0] ret);
        vec_t v;
        v.r = r; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy;
        v.ctl = ctl; v.tr = tr; v.cs = cs; v.ret = ret;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        step("rst", 1'b1, 7'h0, 3'd0, 1'b0, 1'b0, E_0, 1'b0, 2'd0, 32'd0);
        step("idle", 1'b0, 7'h0, 3'd0, 1'b0, 1'b0, E_0, 1'b0, 2'd0, 32'd0);
    endtask

    initial begin
        E_0   = '0;
        E_FW  = c(1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 0, 2'd0);
        E_FR  = c(1, 0, 0, 1, 1, 0, 2'd0, 2'd1, 2'd0, 0, 2'd0);
        E_DEC = c(0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 0, 2'd0);
        E_MA  = c(0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 0, 2'd0);
        E_MR  = c(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
        E_MW  = c(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0);
        E_WBM = c(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 2'd1);
        E_XR  = c(0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd2, 0, 2'd0);
        E_XI  = c(0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd2, 0, 2'd0);
        E_WBA = c(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 2'd0);
        E_BT  = c(0, 0, 0, 0, 1, 1, 2'd1, 2'd0, 2'd1, 0, 2'd0);
        E_BN  = c(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd1, 0, 2'd0);
        E_JAL = c(0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 2'd0, 1, 2'd2);
        E_LUI = c(0, 0, 0, 0, 0, 0, 2'd3, 2'd2, 2'd0, 0, 2'd0);

        // reset, idle
        add(1, 7'h0, 0, 0, 0, E_0,   0, 0, 0);
        add(0, 7'h0, 0, 0, 0, E_0,   0, 0, 0);
        // R-type
        add(0, OR_,  0, 0, 1, E_FR,  0, 0, 0);
        add(0, OR_,  0, 0, 1, E_DEC, 0, 0, 0);
        add(0, OR_,  0, 0, 1, E_XR,  0, 0, 0);
        add(0, OR_,  0, 0, 1, E_WBA, 0, 0, 0);
        // I-type
        add(0, OI,   0, 0, 1, E_FR,  0, 0, 1);
        add(0, OI,   0, 0, 1, E_DEC, 0, 0, 1);
        add(0, OI,   0, 0, 1, E_XI,  0, 0, 1);
        add(0, OI,   0, 0, 1, E_WBA, 0, 0, 1);
        // load, 3 wait states in fetch and memrd
        add(0, OL,   0, 0, 0, E_FW,  0, 0, 2);
        add(0, OL,   0, 0, 0, E_FW,  0, 0, 2);
        add(0, OL,   0, 0, 0, E_FW,  0, 0, 2);
        add(0, OL,   0, 0, 1, E_FR,  0, 0, 2);
        add(0, OL,   0, 0, 1, E_DEC, 0, 0, 2);
        add(0, OL,   0, 0, 1, E_MA,  0, 0, 2);
        add(0, OL,   0, 0, 0, E_MR,  0, 0, 2);
        add(0, OL,   0, 0, 0, E_MR,  0, 0, 2);
        add(0, OL,   0, 0, 0, E_MR,  0, 0, 2);
        add(0, OL,   0, 0, 1, E_MR,  0, 0, 2);
        add(0, OL,   0, 0, 1, E_WBM, 0, 0, 2);
        // store, one wait state
        add(0, OS,   0, 0, 1, E_FR,  0, 0, 3);
        add(0, OS,   0, 0, 1, E_DEC, 0, 0, 3);
        add(0, OS,   0, 0, 1, E_MA,  0, 0, 3);
        add(0, OS,   0, 0, 0, E_MW,  0, 0, 3);
        add(0, OS,   0, 0, 1, E_MW,  0, 0, 3);
        // BEQ zero=1 taken
        add(0, OB,   0, 1, 1, E_FR,  0, 0, 4);
        add(0, OB,   0, 1, 1, E_DEC, 0, 0, 4);
        add(0, OB,   0, 1, 1, E_BT,  0, 0, 4);
        // BNE zero=1 not taken
        add(0, OB,   1, 1, 1, E_FR,  0, 0, 5);
        add(0, OB,   1, 1, 1, E_DEC, 0, 0, 5);
        add(0, OB,   1, 1, 1, E_BN,  0, 0, 5);
        // BNE zero=0 taken
        add(0, OB,   1, 0, 1, E_FR,  0, 0, 6);
        add(0, OB,   1, 0, 1, E_DEC, 0, 0, 6);
        add(0, OB,   1, 0, 1, E_BT,  0, 0, 6);
        // JAL
        add(0, OJ,   0, 0, 1, E_FR,  0, 0, 7);
        add(0, OJ,   0, 0, 1, E_DEC, 0, 0, 7);
        add(0, OJ,   0, 0, 1, E_JAL, 0, 0, 7);
        // illegal opcode, trap is sticky
        add(0, OX,   0, 0, 1, E_FR,  0, 0, 8);
        add(0, OX,   0, 0, 1, E_DEC, 0, 0, 8);
        add(0, OX,   0, 0, 1, E_0,   1, 1, 8);
        add(0, OR_,  0, 0, 1, E_0,   1, 1, 8);
        // reset clears everything
        add(1, OR_,  0, 0, 1, E_0,   0, 0, 0);
        add(0, OR_,  0, 0, 1, E_0,   0, 0, 0);

        foreach (tbl[i])
            step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].op, tbl[i].f3,
                 tbl[i].z, tbl[i].rdy, tbl[i].ctl, tbl[i].tr,
                 tbl[i].cs, tbl[i].ret);

        // async reset mid-fetch with MemReq high
        step("A_f",   0, OR_, 0, 0, 1, E_FR,  0, 0, 0);
        step("A_d",   0, OR_, 0, 0, 1, E_DEC, 0, 0, 0);
        step("A_x",   0, OR_, 0, 0, 1, E_XR,  0, 0, 0);
        step("A_wb",  0, OR_, 0, 0, 1, E_WBA, 0, 0, 0);
        step("A_fw",  0, OR_, 0, 0, 0, E_FW,  0, 0, 1);
        @(posedge Clk);
        #3;
        chk("A_memreq_pre", 50'(MemReq), 50'd1);
        Rst = 1'b1;
        #1;
        chk("A_async_rst", {w_ctl, Trap, Trap_cause, Retired}, 50'd0);
        step("A_hold", 1, OR_, 0, 0, 0, E_0,  0, 0, 0);
        step("A_idle", 0, OR_, 0, 0, 0, E_0,  0, 0, 0);
        step("A_fch",  0, OR_, 0, 0, 0, E_FW, 0, 0, 0);

        // timeout: 15 wait cycles, then a 16th without ready traps
        do_reset();
        for (int i = 0; i < 15; i++)
            step($sformatf("B_w%0d", i), 0, OR_, 0, 0, 0, E_FW, 0, 0, 0);
        step("B_lim",  0, OR_, 0, 0, 0, E_FW, 0, 0, 0);
        step("B_trap", 0, OR_, 0, 0, 1, E_0,  1, 2, 0);

        // ready on the limit cycle wins
        do_reset();
        for (int i = 0; i < 15; i++)
            step($sformatf("C_w%0d", i), 0, OR_, 0, 0, 0, E_FW, 0, 0, 0);
        step("C_lim", 0, OR_, 0, 0, 1, E_FR,  0, 0, 0);
        step("C_dec", 0, OR_, 0, 0, 1, E_DEC, 0, 0, 0);

        // illegal branch funct3
        do_reset();
        step("D_f",    0, OB, 2, 0, 1, E_FR,  0, 0, 0);
        step("D_d",    0, OB, 2, 0, 1, E_DEC, 0, 0, 0);
        step("D_br",   0, OB, 2, 1, 1, E_BN,  0, 0, 0);
        step("D_trap", 0, OB, 2, 1, 1, E_0,   1, 3, 0);

        // LUI
        do_reset();
        step("E_f", 0, OU, 0, 0, 1, E_FR,  0, 0, 0);
        step("E_d", 0, OU, 0, 0, 1, E_DEC, 0, 0, 0);
`ifdef MULTICYCLE_LUI_EN
        step("E_x",  0, OU, 0, 0, 1, E_LUI, 0, 0, 0);
        step("E_wb", 0, OU, 0, 0, 1, E_WBA, 0, 0, 0);
        step("E_rt", 0, OU, 0, 0, 0, E_FW,  0, 0, 1);
`else
        step("E_trap", 0, OU, 0, 0, 1, E_0, 1, 1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
